// File: rtl/usbf_mem_sched_pkg.sv
// Shared definitions for the packet-SSRAM scheduler.
// - ms_state_e       : one-hot scheduler states
// - StarveMaxDefault : default max PE grants while a WISHBONE request waits
package usbf_mem_sched_pkg;

  typedef enum logic [3:0] {
    StIdle  = 4'b0001,
    StWbAcc = 4'b0010,
    StWbDat = 4'b0100,
    StWbAck = 4'b1000
  } ms_state_e;

  localparam int unsigned StarveMaxDefault = 4;

endpackage

// File: rtl/usbf_mem_sched.sv
// Packet-SSRAM scheduler: arbitrates the single-port SSRAM between the protocol
// engine (zero-wait priority) and the WISHBONE memory-arbiter path. A starvation
// counter forces a WISHBONE slot after STARVE_MAX back-to-back PE grants.
// Ports:
//   phy_clk, rst                 : clock, asynchronous active-low reset
//   mreq/mwe/madr/mdin/mdout/mack : PE side, mack combinational grant
//   wreq/wwe/wadr/wdin/wdout/wack : WISHBONE side, wdout registered and held,
//                                   wack a one-cycle pulse
//   sram_adr/dout/din/re/we       : SSRAM port, read data one cycle after sram_re
module usbf_mem_sched
  import usbf_mem_sched_pkg::*;
#(
  parameter int unsigned AW         = 15,
  parameter int unsigned STARVE_MAX = StarveMaxDefault,
  parameter int unsigned CW         = 3
) (
  input  logic          phy_clk,
  input  logic          rst,
  input  logic          mreq,
  input  logic          mwe,
  input  logic [AW-1:0] madr,
  input  logic [31:0]   mdin,
  output logic [31:0]   mdout,
  output logic          mack,
  input  logic          wreq,
  input  logic          wwe,
  input  logic [AW-1:0] wadr,
  input  logic [31:0]   wdin,
  output logic [31:0]   wdout,
  output logic          wack,
  output logic [AW-1:0] sram_adr,
  output logic [31:0]   sram_dout,
  input  logic [31:0]   sram_din,
  output logic          sram_re,
  output logic          sram_we
);

  ms_state_e     state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic [31:0]   wdout_q, wdout_d;
  logic          wb_we_q, wb_we_d;

  logic          starved;
  logic          wb_win;
  logic          mack_c;
  logic          re_c;
  logic          we_c;

  assign starved = (starve_q == CW'(STARVE_MAX));
  assign wb_win  = wreq & (~mreq | starved);

  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    wdout_d   = wdout_q;
    wb_we_d   = wb_we_q;
    mack_c    = 1'b0;
    re_c      = 1'b0;
    we_c      = 1'b0;
    sram_adr  = madr;
    sram_dout = mdin;

    unique case (state_q)
      StIdle: begin
        if (wb_win) begin
          state_d = StWbAcc;
        end else if (mreq) begin
          mack_c = 1'b1;
          we_c   = mwe;
          re_c   = ~mwe;
          // Count PE grants only while WISHBONE is actually kept waiting.
          if (wreq && !starved) begin
            starve_d = starve_q + 1'b1;
          end
        end
      end
      StWbAcc: begin
        sram_adr  = wadr;
        sram_dout = wdin;
        we_c      = wwe;
        re_c      = ~wwe;
        // Direction is latched here; later changes of wwe must not matter.
        wb_we_d   = wwe;
        starve_d  = '0;
        state_d   = StWbDat;
      end
      StWbDat: begin
        if (!wb_we_q) begin
          wdout_d = sram_din;
        end
        state_d = StWbAck;
      end
      StWbAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Strobes and grant are forced low the instant reset asserts, even in IDLE
  // with a PE request pending.
  assign mack    = rst & mack_c;
  assign sram_re = rst & re_c;
  assign sram_we = rst & we_c;
  assign wack    = (state_q == StWbAck);
  assign wdout   = wdout_q;
  assign mdout   = sram_din;

  always_ff @(posedge phy_clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      starve_q <= '0;
      wdout_q  <= '0;
      wb_we_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      wdout_q  <= wdout_d;
      wb_we_q  <= wb_we_d;
    end
  end

endmodule

// File: tb/tb_usbf_mem_sched.sv
// Randomized scoreboard bench for usbf_mem_sched (STARVE_MAX=4) plus a short
// directed run on a STARVE_MAX=0 instance.
module tb_usbf_mem_sched;

  localparam int unsigned AW   = 15;
  localparam int unsigned SM   = 4;
  localparam int unsigned NADR = 64;

  typedef struct {
    int unsigned cyc;
    logic [31:0] data;
  } exp_t;

  logic          phy_clk = 1'b0;
  logic          rst;
  logic          mreq, mwe, mack;
  logic [AW-1:0] madr;
  logic [31:0]   mdin, mdout;
  logic          wreq, wwe, wack;
  logic [AW-1:0] wadr;
  logic [31:0]   wdin, wdout;
  logic [AW-1:0] sram_adr;
  logic [31:0]   sram_dout, sram_din;
  logic          sram_re, sram_we;

  logic          z_mreq, z_mwe, z_mack, z_wreq, z_wwe, z_wack, z_sram_re, z_sram_we;
  logic [AW-1:0] z_madr, z_wadr, z_sram_adr;
  logic [31:0]   z_mdin, z_mdout, z_wdin, z_wdout, z_sram_dout;
  logic [31:0]   z_sram_din = 32'h0;

  always #5 phy_clk = ~phy_clk;

  usbf_mem_sched #(.AW(AW), .STARVE_MAX(SM), .CW(3)) u_dut (
    .phy_clk(phy_clk), .rst(rst),
    .mreq(mreq), .mwe(mwe), .madr(madr), .mdin(mdin), .mdout(mdout), .mack(mack),
    .wreq(wreq), .wwe(wwe), .wadr(wadr), .wdin(wdin), .wdout(wdout), .wack(wack),
    .sram_adr(sram_adr), .sram_dout(sram_dout), .sram_din(sram_din),
    .sram_re(sram_re), .sram_we(sram_we)
  );

  usbf_mem_sched #(.AW(AW), .STARVE_MAX(0), .CW(3)) u_dut_z (
    .phy_clk(phy_clk), .rst(rst),
    .mreq(z_mreq), .mwe(z_mwe), .madr(z_madr), .mdin(z_mdin), .mdout(z_mdout),
    .mack(z_mack),
    .wreq(z_wreq), .wwe(z_wwe), .wadr(z_wadr), .wdin(z_wdin), .wdout(z_wdout),
    .wack(z_wack),
    .sram_adr(z_sram_adr), .sram_dout(z_sram_dout), .sram_din(z_sram_din),
    .sram_re(z_sram_re), .sram_we(z_sram_we)
  );

  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  logic        preload, chk_en, m_clear;
  int unsigned pe_prob, wb_prob;

  always @(posedge phy_clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(int i);
    return 32'h9e37_79b9 * (i + 1) ^ 32'h0101_0101;
  endfunction

  function void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // SSRAM: synchronous write, registered read.
  logic [31:0] mem [NADR];
  always @(posedge phy_clk) begin
    if (preload) begin
      for (int i = 0; i < NADR; i++) mem[i] <= init_word(i);
    end else begin
      if (sram_we) mem[sram_adr[5:0]] <= sram_dout;
      if (sram_re) sram_din <= mem[sram_adr[5:0]];
    end
  end

  // Reference model: transaction-level view of the arbiter.
  // m_phase: 0 idle, 1 WB address, 2 WB data, 3 WB ack.
  logic [31:0] ref_mem [NADR];
  int          m_phase;
  int unsigned m_starve;
  logic        m_txn_we;
  logic [AW-1:0] m_txn_adr;
  logic [31:0] m_txn_din;
  logic [31:0] last_rd;
  logic        m_win, m_exp_mack;
  exp_t        wb_q[$];
  exp_t        pe_q[$];

  always @(negedge phy_clk) begin
    if (preload) begin
      for (int i = 0; i < NADR; i++) ref_mem[i] = init_word(i);
    end
    if (m_clear) begin
      m_phase  = 0;
      m_starve = 0;
      last_rd  = '0;
    end else if (chk_en) begin
      case (m_phase)
        0: begin
          m_win      = wreq && (!mreq || m_starve == SM);
          m_exp_mack = mreq && !m_win;
          chk("mack", {31'b0, mack}, {31'b0, m_exp_mack});
          chk("sram_re_idle", {31'b0, sram_re}, {31'b0, m_exp_mack & ~mwe});
          chk("sram_we_idle", {31'b0, sram_we}, {31'b0, m_exp_mack & mwe});
          chk("wack_idle", {31'b0, wack}, 32'h0);
          if (m_exp_mack) begin
            chk("pe_adr", {17'b0, sram_adr}, {17'b0, madr});
            if (mwe) begin
              chk("pe_wdata", sram_dout, mdin);
              ref_mem[madr[5:0]] = mdin;
            end else begin
              pe_q.push_back('{cyc + 1, ref_mem[madr[5:0]]});
            end
            if (wreq && m_starve < SM) m_starve++;
          end
          if (m_win) begin
            m_txn_we  = wwe;
            m_txn_adr = wadr;
            m_txn_din = wdin;
            m_phase   = 1;
          end
        end
        1: begin
          chk("mack_wb_acc", {31'b0, mack}, 32'h0);
          chk("sram_re_acc", {31'b0, sram_re}, {31'b0, ~m_txn_we});
          chk("sram_we_acc", {31'b0, sram_we}, {31'b0, m_txn_we});
          chk("wb_adr", {17'b0, sram_adr}, {17'b0, m_txn_adr});
          chk("wack_acc", {31'b0, wack}, 32'h0);
          if (m_txn_we) begin
            chk("wb_wdata", sram_dout, m_txn_din);
            ref_mem[m_txn_adr[5:0]] = m_txn_din;
          end else begin
            last_rd = ref_mem[m_txn_adr[5:0]];
          end
          wb_q.push_back('{cyc + 2, last_rd});
          m_starve = 0;
          m_phase  = 2;
        end
        2: begin
          chk("mack_wb_dat", {31'b0, mack}, 32'h0);
          chk("strobes_dat", {30'b0, sram_re, sram_we}, 32'h0);
          chk("wack_dat", {31'b0, wack}, 32'h0);
          m_phase = 3;
        end
        default: begin
          chk("mack_wb_ack", {31'b0, mack}, 32'h0);
          chk("strobes_ack", {30'b0, sram_re, sram_we}, 32'h0);
          m_phase = 0;
        end
      endcase
    end
  end

  // Monitor: pops expectations when the DUT presents wack or PE read data.
  exp_t mon_e;
  always @(negedge phy_clk) begin
    if (m_clear) begin
      wb_q.delete();
      pe_q.delete();
    end else if (chk_en) begin
      if (wb_q.size() > 0 && wb_q[0].cyc < cyc) begin
        mon_e = wb_q.pop_front();
        chk("wack_missing", 32'h0, 32'h1);
      end
      if (wack) begin
        if (wb_q.size() == 0) begin
          chk("wack_spurious", 32'h1, 32'h0);
        end else begin
          mon_e = wb_q.pop_front();
          chk("wack_cycle", cyc, mon_e.cyc);
          chk("wdout", wdout, mon_e.data);
        end
      end
      if (pe_q.size() > 0 && pe_q[0].cyc <= cyc) begin
        mon_e = pe_q.pop_front();
        chk("mdout", mdout, mon_e.data);
      end
    end
  end

  // One stimulus cycle: PE holds its request until granted, WISHBONE until acked.
  logic s_mack, s_wack;
  task automatic drive_cycle();
    @(negedge phy_clk);
    s_mack = mack;
    s_wack = wack;
    @(posedge phy_clk);
    #1;
    if (!mreq || s_mack) begin
      mreq = ($urandom_range(0, 99) < pe_prob);
      mwe  = 1'($urandom_range(0, 1));
      madr = AW'($urandom_range(0, NADR - 1));
      mdin = $urandom;
    end
    if (wreq && !s_wack) begin
      // Past the address phase the request fields must be ignored: scramble them.
      if (m_phase == 2 || m_phase == 3) begin
        wwe  = 1'($urandom_range(0, 1));
        wadr = AW'($urandom_range(0, NADR - 1));
        wdin = $urandom;
      end
    end else begin
      wreq = ($urandom_range(0, 99) < wb_prob);
      wwe  = 1'($urandom_range(0, 1));
      wadr = AW'($urandom_range(0, NADR - 1));
      wdin = $urandom;
    end
  endtask

  task automatic run(int n, int unsigned pp, int unsigned wp);
    pe_prob = pp;
    wb_prob = wp;
    repeat (n) drive_cycle();
  endtask

  initial begin
    bit found;
    rst = 1'b0; preload = 1'b1; chk_en = 1'b0; m_clear = 1'b1;
    mreq = 0; mwe = 0; madr = '0; mdin = '0;
    wreq = 0; wwe = 0; wadr = '0; wdin = '0;
    z_mreq = 0; z_mwe = 0; z_madr = '0; z_mdin = '0;
    z_wreq = 0; z_wwe = 0; z_wadr = '0; z_wdin = '0;
    #1;
    chk("rst_wack", {31'b0, wack}, 32'h0);
    chk("rst_strobes", {30'b0, sram_re, sram_we}, 32'h0);
    chk("rst_wdout", wdout, 32'h0);
    repeat (2) @(negedge phy_clk);
    preload = 1'b0;
    @(posedge phy_clk);
    #3;
    rst = 1'b1; m_clear = 1'b0; chk_en = 1'b1;

    run(600, 50, 30);
    run(300, 100, 100);   // PE saturating: starvation guard must kick in
    run(300, 100, 20);
    run(200, 0, 100);     // back-to-back WISHBONE accesses

    // Abort a WISHBONE read in its data phase.
    pe_prob = 0;
    wb_prob = 100;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      drive_cycle();
      if (m_phase == 2 && !m_txn_we) found = 1;
    end
    if (!found) begin
      chk("reset_setup_timeout", 32'h0, 32'h1);
    end else begin
      #2;
      rst = 1'b0; chk_en = 1'b0; m_clear = 1'b1;
      #1;
      chk("abort_strobes", {30'b0, sram_re, sram_we}, 32'h0);
      chk("abort_wack", {31'b0, wack}, 32'h0);
      chk("abort_wdout", wdout, 32'h0);
      mreq = 0; wreq = 0;
      @(posedge phy_clk);
      @(posedge phy_clk);
      #3;
      rst = 1'b1; m_clear = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge phy_clk);
        chk("no_wack_after_reset", {31'b0, wack}, 32'h0);
      end
      chk_en = 1'b1;
    end

    run(400, 70, 50);
    run(12, 0, 0);        // drain outstanding requests
    chk("wb_q_drain", 32'(wb_q.size()), 32'h0);
    chk("pe_q_drain", 32'(pe_q.size()), 32'h0);
    chk("wdout_hold", wdout, last_rd);
    for (int i = 0; i < NADR; i++) chk("sram_contents", mem[i], ref_mem[i]);

    // STARVE_MAX=0: WISHBONE preempts a simultaneous PE request.
    chk_en = 1'b0;
    @(posedge phy_clk);
    #1;
    z_mreq = 1; z_wreq = 1; z_wwe = 0; z_wadr = AW'(5);
    @(negedge phy_clk);
    chk("z_mack_c0", {31'b0, z_mack}, 32'h0);
    chk("z_re_c0", {31'b0, z_sram_re}, 32'h0);
    @(negedge phy_clk);
    chk("z_mack_c1", {31'b0, z_mack}, 32'h0);
    chk("z_re_c1", {31'b0, z_sram_re}, 32'h1);
    chk("z_adr_c1", {17'b0, z_sram_adr}, 32'h5);
    @(negedge phy_clk);
    chk("z_wack_c2", {31'b0, z_wack}, 32'h0);
    @(negedge phy_clk);
    chk("z_wack_c3", {31'b0, z_wack}, 32'h1);
    chk("z_mack_c3", {31'b0, z_mack}, 32'h0);
    @(posedge phy_clk);
    #1;
    z_wreq = 0;
    @(negedge phy_clk);
    chk("z_mack_c4", {31'b0, z_mack}, 32'h1);
    chk("z_wack_c4", {31'b0, z_wack}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
